// File: rtl/controle_pkg.sv
// Shared encodings for the Horner evaluation controller: FSM states and the
// operand/routing select codes seen by the datapath.
package controle_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CARGA = 3'd1,
      MUL   = 3'd2,
      SOMA  = 3'd3,
      SALVA = 3'd4,
      FIM   = 3'd5
   } estado_t;

   // ALU operand A
   localparam logic [1:0] SEL_A_ZERO = 2'b00;
   localparam logic [1:0] SEL_A_COEF = 2'b01;
   localparam logic [1:0] SEL_A_X    = 2'b10;
   localparam logic [1:0] SEL_A_H    = 2'b11;

   // ALU operand B
   localparam logic [1:0] SEL_B_ZERO = 2'b00;
   localparam logic [1:0] SEL_B_COEF = 2'b01;
   localparam logic [1:0] SEL_B_H    = 2'b11;

   // h register input routing
   localparam logic [1:0] SEL_H_HOLD = 2'b00;
   localparam logic [1:0] SEL_H_ALU  = 2'b11;

   localparam logic OP_SOMA = 1'b0;
   localparam logic OP_MUL  = 1'b1;

endpackage

// File: rtl/contador_coef.sv
// Coefficient index register: parallel load, saturating decrement, zero flag.
module contador_coef #(
   parameter int W_IDX = 2,
   parameter int INIT  = 3
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             load,
   input  logic [W_IDX-1:0] valor,
   input  logic             dec,
   output logic [W_IDX-1:0] idx,
   output logic             zero
);

   localparam logic [W_IDX-1:0] VAL_INIT = W_IDX'(INIT);
   localparam logic [W_IDX-1:0] UM       = W_IDX'(1);

   always_ff @(posedge ck) begin
      if (rst)
         idx <= VAL_INIT;
      else if (load)
         idx <= valor;
      else if (dec && (idx != '0))
         idx <= idx - UM;
   end

   assign zero = (idx == '0);

endmodule

// File: rtl/controle_horner.sv
// Control FSM for Horner polynomial evaluation: h=a_GRAU, then h=h*x+a_i
// down to i=0, finally s=h. Moore outputs except lh, which follows pronto.
module controle_horner
   import controle_pkg::*;
#(
   parameter int GRAU  = 3,
   parameter int W_IDX = (GRAU < 1) ? 1 : $clog2(GRAU + 1)
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             inicio,
   input  logic             pronto,
   output logic             lx,
   output logic [1:0]       m0,
   output logic [1:0]       m1,
   output logic [1:0]       m2,
   output logic             h,
   output logic             lh,
   output logic             ls,
   output logic [W_IDX-1:0] idx,
   output logic             busy,
   output logic             done
);

   localparam logic [W_IDX-1:0] IDX_GRAU = W_IDX'(GRAU);
   localparam logic [W_IDX-1:0] IDX_PRIM = (GRAU > 0) ? W_IDX'(GRAU - 1) : '0;

   estado_t          estado_q, estado_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [W_IDX-1:0] cnt_val;

   contador_coef #(
      .W_IDX (W_IDX),
      .INIT  (GRAU)
   ) u_contador (
      .ck    (ck),
      .rst   (rst),
      .load  (cnt_load),
      .valor (cnt_val),
      .dec   (cnt_dec),
      .idx   (idx),
      .zero  (cnt_zero)
   );

   always_ff @(posedge ck) begin
      if (rst)
         estado_q <= IDLE;
      else
         estado_q <= estado_d;
   end

   // Next state and index control; the index is re-armed to GRAU on the way
   // back to IDLE so it already reads GRAU during the idle cycles.
   always_comb begin
      estado_d = estado_q;
      cnt_load = 1'b0;
      cnt_val  = IDX_GRAU;
      cnt_dec  = 1'b0;
      case (estado_q)
         IDLE: begin
            if (inicio)
               estado_d = CARGA;
         end
         CARGA: begin
            if (GRAU == 0) begin
               estado_d = SALVA;
            end else begin
               estado_d = MUL;
               cnt_load = 1'b1;
               cnt_val  = IDX_PRIM;
            end
         end
         MUL: begin
            if (pronto)
               estado_d = SOMA;
         end
         SOMA: begin
            if (pronto) begin
               if (cnt_zero) begin
                  estado_d = SALVA;
               end else begin
                  estado_d = MUL;
                  cnt_dec  = 1'b1;
               end
            end
         end
         SALVA: estado_d = FIM;
         FIM: begin
            estado_d = IDLE;
            cnt_load = 1'b1;
         end
         default: begin
            estado_d = IDLE;
            cnt_load = 1'b1;
         end
      endcase
   end

   always_comb begin
      lx   = 1'b0;
      m0   = SEL_A_ZERO;
      m1   = SEL_B_ZERO;
      m2   = SEL_H_HOLD;
      h    = OP_SOMA;
      lh   = 1'b0;
      ls   = 1'b0;
      busy = 1'b1;
      done = 1'b0;
      case (estado_q)
         IDLE: busy = 1'b0;
         CARGA: begin
            lx = 1'b1;
            lh = 1'b1;
            m0 = SEL_A_COEF;
            m1 = SEL_B_ZERO;
            m2 = SEL_H_ALU;
         end
         MUL: begin
            h  = OP_MUL;
            m0 = SEL_A_X;
            m1 = SEL_B_H;
            m2 = SEL_H_ALU;
            lh = pronto;
         end
         SOMA: begin
            m0 = SEL_A_H;
            m1 = SEL_B_COEF;
            m2 = SEL_H_ALU;
            lh = pronto;
         end
         SALVA: begin
            ls = 1'b1;
            m0 = SEL_A_H;
            m1 = SEL_B_ZERO;
         end
         FIM: done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_controle_horner.sv
// Directed bench for controle_horner: GRAU=3 instance plus a GRAU=0 instance.
module tb_controle_horner;

   localparam int T_IDLE = 0, T_CARGA = 1, T_MUL = 2, T_SOMA = 3, T_SALVA = 4, T_FIM = 5;

   logic ck = 1'b0;
   logic rst, inicio, inicio0, pronto;

   logic       lx, h, lh, ls, busy, done;
   logic [1:0] m0, m1, m2, idx;
   logic       b_lx, b_h, b_lh, b_ls, b_busy, b_done;
   logic [1:0] b_m0, b_m1, b_m2;
   logic [0:0] b_idx;

   logic [13:0] obs_a, obs_b;
   int ncmp = 0;
   int nfail = 0;
   int ncyc = 0;
   int t0;
   int nls;

   always #5 ck = ~ck;

   controle_horner #(.GRAU(3)) dut (
      .ck(ck), .rst(rst), .inicio(inicio), .pronto(pronto),
      .lx(lx), .m0(m0), .m1(m1), .m2(m2), .h(h), .lh(lh), .ls(ls),
      .idx(idx), .busy(busy), .done(done)
   );

   controle_horner #(.GRAU(0)) dut0 (
      .ck(ck), .rst(rst), .inicio(inicio0), .pronto(pronto),
      .lx(b_lx), .m0(b_m0), .m1(b_m1), .m2(b_m2), .h(b_h), .lh(b_lh), .ls(b_ls),
      .idx(b_idx), .busy(b_busy), .done(b_done)
   );

   assign obs_a = {lx, m0, m1, m2, h, lh, ls, idx, busy, done};
   assign obs_b = {b_lx, b_m0, b_m1, b_m2, b_h, b_lh, b_ls, 1'b0, b_idx, b_busy, b_done};

   // {lx, m0, m1, m2, h, lh, ls, idx, busy, done} expected for each state
   function automatic logic [13:0] expv(int st, bit lhv, logic [1:0] ix);
      case (st)
         T_CARGA: return {1'b1, 2'b01, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, ix, 1'b1, 1'b0};
         T_MUL:   return {1'b0, 2'b10, 2'b11, 2'b11, 1'b1, lhv,  1'b0, ix, 1'b1, 1'b0};
         T_SOMA:  return {1'b0, 2'b11, 2'b01, 2'b11, 1'b0, lhv,  1'b0, ix, 1'b1, 1'b0};
         T_SALVA: return {1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, ix, 1'b1, 1'b0};
         T_FIM:   return {1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, ix, 1'b1, 1'b1};
         default: return {1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, ix, 1'b0, 1'b0};
      endcase
   endfunction

   task automatic tick();
      @(posedge ck);
      #1;
      ncyc++;
   endtask

   task automatic chka(string tag, int st, bit lhv, logic [1:0] ix);
      logic [13:0] e;
      #1;
      e = expv(st, lhv, ix);
      ncmp++;
      assert (obs_a === e) else begin
         nfail++;
         $error("FAIL %s: observed %b required %b", tag, obs_a, e);
      end
   endtask

   task automatic chkb(string tag, int st);
      logic [13:0] e;
      #1;
      e = expv(st, 1'b0, 2'b00);
      ncmp++;
      assert (obs_b === e) else begin
         nfail++;
         $error("FAIL %s: observed %b required %b", tag, obs_b, e);
      end
   endtask

   task automatic chkn(string tag, int obs, int req);
      ncmp++;
      assert (obs === req) else begin
         nfail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, req);
      end
   endtask

   // Full GRAU=3 evaluation from CARGA through FIM with pronto held high.
   task automatic run_full(string tag, bit ini);
      inicio = ini;
      pronto = 1'b1;
      chka({tag, "_carga"}, T_CARGA, 1'b1, 2'd3); tick();
      for (int i = 2; i >= 0; i--) begin
         chka({tag, "_mul"}, T_MUL, 1'b1, 2'(i)); tick();
         chka({tag, "_soma"}, T_SOMA, 1'b1, 2'(i)); tick();
      end
      chka({tag, "_salva"}, T_SALVA, 1'b0, 2'd0); tick();
      chka({tag, "_fim"}, T_FIM, 1'b0, 2'd0);
   endtask

   // Hold pronto low four cycles, then raise it for one.
   task automatic slow_step(string tag, int st, logic [1:0] ix);
      pronto = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chka({tag, "_wait"}, st, 1'b0, ix); tick();
      end
      pronto = 1'b1;
      chka({tag, "_go"}, st, 1'b1, ix); tick();
   endtask

   initial begin
      rst = 1'b1; inicio = 1'b0; inicio0 = 1'b0; pronto = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chka("reset_a", T_IDLE, 1'b0, 2'd3);
      chkb("reset_b", T_IDLE);

      // pronto ignored in IDLE
      pronto = 1'b1;
      chka("idle_pronto", T_IDLE, 1'b0, 2'd3); tick();
      chka("idle_stay", T_IDLE, 1'b0, 2'd3);

      // nominal run, GRAU=3
      inicio = 1'b1;
      chka("t1_idle", T_IDLE, 1'b0, 2'd3); tick();
      t0 = ncyc;
      run_full("t1", 1'b0);
      chkn("t1_latency", ncyc - t0, 8);
      tick();
      chka("t1_back_idle", T_IDLE, 1'b0, 2'd3);

      // pronto stalls in every MUL/SOMA
      inicio = 1'b1;
      chka("t2_idle", T_IDLE, 1'b0, 2'd3); tick();
      t0 = ncyc;
      inicio = 1'b0;
      pronto = 1'b0;
      chka("t2_carga", T_CARGA, 1'b1, 2'd3); tick();
      for (int i = 2; i >= 0; i--) begin
         slow_step("t2_mul", T_MUL, 2'(i));
         slow_step("t2_soma", T_SOMA, 2'(i));
      end
      pronto = 1'b1;
      chka("t2_salva", T_SALVA, 1'b0, 2'd0); tick();
      chka("t2_fim", T_FIM, 1'b0, 2'd0);
      chkn("t2_latency", ncyc - t0, 32);
      pronto = 1'b0;
      tick();
      chka("t2_back_idle", T_IDLE, 1'b0, 2'd3);

      // GRAU=0 instance: CARGA, SALVA, FIM
      inicio0 = 1'b1;
      chkb("t3_idle", T_IDLE); tick();
      inicio0 = 1'b0;
      nls = 0;
      chkb("t3_carga", T_CARGA); nls += int'(b_ls); tick();
      chkb("t3_salva", T_SALVA); nls += int'(b_ls); tick();
      chkb("t3_fim", T_FIM); nls += int'(b_ls); tick();
      chkb("t3_idle_end", T_IDLE); nls += int'(b_ls);
      chkn("t3_ls_count", nls, 1);

      // inicio held high: back-to-back runs, one IDLE cycle between
      inicio = 1'b1;
      chka("t4_idle", T_IDLE, 1'b0, 2'd3); tick();
      run_full("t4a", 1'b1); tick();
      chka("t4_gap", T_IDLE, 1'b0, 2'd3); tick();
      run_full("t4b", 1'b1); tick();
      inicio = 1'b0;
      chka("t4_no_queue1", T_IDLE, 1'b0, 2'd3); tick();
      chka("t4_no_queue2", T_IDLE, 1'b0, 2'd3);

      // reset in SOMA with idx=1, then a fresh run
      inicio = 1'b1;
      pronto = 1'b1;
      chka("t5_idle", T_IDLE, 1'b0, 2'd3); tick();
      inicio = 1'b0;
      chka("t5_carga", T_CARGA, 1'b1, 2'd3); tick();
      chka("t5_mul2", T_MUL, 1'b1, 2'd2); tick();
      chka("t5_soma2", T_SOMA, 1'b1, 2'd2); tick();
      chka("t5_mul1", T_MUL, 1'b1, 2'd1); tick();
      rst = 1'b1;
      chka("t5_soma1", T_SOMA, 1'b1, 2'd1); tick();
      rst = 1'b0;
      pronto = 1'b0;
      chka("t5_after_rst", T_IDLE, 1'b0, 2'd3); tick();
      inicio = 1'b1;
      chka("t5_restart", T_IDLE, 1'b0, 2'd3); tick();
      t0 = ncyc;
      run_full("t5r", 1'b0);
      chkn("t5_latency", ncyc - t0, 8);
      tick();
      chka("t5_end", T_IDLE, 1'b0, 2'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
